// File: rtl/int_freelist.sv
// int_freelist: integer physical-register free list for the rename stage.
// Free indices live in a circular FIFO with a speculative head (rename),
// an architectural head (commit) and a tail (release), so a squash restores
// the allocation state in one cycle by copying the architectural head.
// Optional build macro: FREELIST_DBLFREE_CHECK_EN adds a per-register
// architectural-free bitmap that drops and flags double releases.

module int_freelist #(
  parameter int WIDTH       = 4,
  parameter int COMMIT_WID  = 4,
  parameter int NUM_PHYREGS = 64,
  localparam int IW = $clog2(NUM_PHYREGS),
  localparam int PW = IW + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                i_alloc_vld,
  output logic                            o_can_alloc,
  output logic [WIDTH-1:0][IW-1:0]        o_alloc_prd_idx,
  input  logic [COMMIT_WID-1:0]           i_dealloc_vld,
  input  logic [COMMIT_WID-1:0][IW-1:0]   i_dealloc_prd_idx,
  input  logic [COMMIT_WID-1:0]           i_commit_alloc_vld,
  input  logic                            i_squash_vld,
  output logic [PW-1:0]                   o_free_count,
  output logic                            o_dblfree_err
);

  typedef logic [IW-1:0] ipr_idx_t;

  ipr_idx_t      fifo_q [NUM_PHYREGS];
  ipr_idx_t      fifo_d [NUM_PHYREGS];
  logic [PW-1:0] spec_head_q, spec_head_d;
  logic [PW-1:0] arch_head_q, arch_head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] free_count_s;
  logic [PW-1:0] commit_cnt_s;
  logic          can_alloc_s;
  logic          alloc_fire_s;
  ipr_idx_t      alloc_off_s;
  ipr_idx_t      push_off_s;
`ifdef FREELIST_DBLFREE_CHECK_EN
  logic [NUM_PHYREGS-1:0] arch_free_q, arch_free_d;
  logic [NUM_PHYREGS-1:0] seen_s;
  logic                   dblfree_hit_s;
  logic                   dblfree_err_q, dblfree_err_d;
`endif

  // Number of set bits in a commit-width lane mask.
  function automatic logic [PW-1:0] count_ones(input logic [COMMIT_WID-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int k = 0; k < COMMIT_WID; k++) begin
      n = n + PW'(v[k]);
    end
    return n;
  endfunction

  assign free_count_s = tail_q - spec_head_q;
  assign can_alloc_s  = (free_count_s >= PW'(WIDTH));
  assign alloc_fire_s = (|i_alloc_vld) && can_alloc_s && !i_squash_vld;
  assign commit_cnt_s = count_ones(i_commit_alloc_vld);
  assign o_can_alloc  = can_alloc_s;
  assign o_free_count = free_count_s;
`ifdef FREELIST_DBLFREE_CHECK_EN
  assign o_dblfree_err = dblfree_err_q;
`else
  assign o_dblfree_err = 1'b0;
`endif

  // Compact requesting lanes onto consecutive entries from the speculative head.
  always_comb begin
    alloc_off_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_alloc_prd_idx[i] = fifo_q[spec_head_q[IW-1:0] + alloc_off_s];
      if (i_alloc_vld[i]) begin
        alloc_off_s = alloc_off_s + IW'(1);
      end else begin
        alloc_off_s = alloc_off_s;
      end
    end
  end

  // Next-state: compacted pushes at the tail, head moves, squash restore.
  always_comb begin
    logic keep_v;
    keep_v     = 1'b0;
    fifo_d     = fifo_q;
    push_off_s = '0;
`ifdef FREELIST_DBLFREE_CHECK_EN
    arch_free_d   = arch_free_q;
    seen_s        = arch_free_q;
    dblfree_hit_s = 1'b0;
    // Entries that leave through the architectural head are no longer free.
    for (int k = 0; k < COMMIT_WID; k++) begin
      if (PW'(k) < commit_cnt_s) begin
        arch_free_d[fifo_q[arch_head_q[IW-1:0] + IW'(k)]] = 1'b0;
      end else begin
        arch_free_d = arch_free_d;
      end
    end
`endif
    for (int j = 0; j < COMMIT_WID; j++) begin
      keep_v = i_dealloc_vld[j] && (i_dealloc_prd_idx[j] != '0);
`ifdef FREELIST_DBLFREE_CHECK_EN
      // A release of an index that is already free (or released earlier in
      // this same cycle) is a double free.
      keep_v = keep_v && !seen_s[i_dealloc_prd_idx[j]];
      if (i_dealloc_vld[j] && !keep_v) begin
        dblfree_hit_s = 1'b1;
      end else begin
        dblfree_hit_s = dblfree_hit_s;
      end
`endif
      if (keep_v) begin
        fifo_d[tail_q[IW-1:0] + push_off_s] = i_dealloc_prd_idx[j];
        push_off_s = push_off_s + IW'(1);
`ifdef FREELIST_DBLFREE_CHECK_EN
        seen_s[i_dealloc_prd_idx[j]]      = 1'b1;
        arch_free_d[i_dealloc_prd_idx[j]] = 1'b1;
`endif
      end else begin
        push_off_s = push_off_s;
      end
    end
    tail_d      = tail_q + {1'b0, push_off_s};
    arch_head_d = arch_head_q + commit_cnt_s;
    if (i_squash_vld) begin
      spec_head_d = arch_head_q + commit_cnt_s;
    end else if (alloc_fire_s) begin
      spec_head_d = spec_head_q + {1'b0, alloc_off_s};
    end else begin
      spec_head_d = spec_head_q;
    end
`ifdef FREELIST_DBLFREE_CHECK_EN
    dblfree_err_d = dblfree_err_q | dblfree_hit_s;
`endif
  end

  // State registers; p0 is never in the list, so the FIFO starts with p1..p(N-1).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_PHYREGS; k++) begin
        fifo_q[k] <= IW'(k + 1);
      end
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= PW'(NUM_PHYREGS - 1);
`ifdef FREELIST_DBLFREE_CHECK_EN
      arch_free_q   <= {{(NUM_PHYREGS-1){1'b1}}, 1'b0};
      dblfree_err_q <= 1'b0;
`endif
    end else begin
      fifo_q      <= fifo_d;
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
`ifdef FREELIST_DBLFREE_CHECK_EN
      arch_free_q   <= arch_free_d;
      dblfree_err_q <= dblfree_err_d;
`endif
    end
  end

  int_freelist_chk #(
    .COMMIT_WID  (COMMIT_WID),
    .NUM_PHYREGS (NUM_PHYREGS)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .free_count  (free_count_s),
    .spec_head   (spec_head_q),
    .arch_head   (arch_head_q),
    .dealloc_vld (i_dealloc_vld),
    .dealloc_idx (i_dealloc_prd_idx)
  );

endmodule

// Invariant checker for the free list pointers and release inputs.
module int_freelist_chk #(
  parameter int COMMIT_WID  = 4,
  parameter int NUM_PHYREGS = 64,
  localparam int IW = $clog2(NUM_PHYREGS),
  localparam int PW = IW + 1
) (
  input logic                          clk,
  input logic                          rst,
  input logic [PW-1:0]                 free_count,
  input logic [PW-1:0]                 spec_head,
  input logic [PW-1:0]                 arch_head,
  input logic [COMMIT_WID-1:0]         dealloc_vld,
  input logic [COMMIT_WID-1:0][IW-1:0] dealloc_idx
);

  // Count bound, head ordering and no release of p0.
  always @(posedge clk) begin
    if (!rst) begin
      assert (free_count <= PW'(NUM_PHYREGS - 1));
      assert (PW'(spec_head - arch_head) <= PW'(NUM_PHYREGS));
      for (int j = 0; j < COMMIT_WID; j++) begin
        assert (!(dealloc_vld[j] && (dealloc_idx[j] == '0)));
      end
    end
  end

endmodule

// File: doc/int_freelist.md
# int_freelist

Integer physical-register free list, directly upstream of the integer RAT. Each cycle it supplies up to WIDTH free physical register indices to the rename stage and accepts up to COMMIT_WID released indices from the RAT's dealloc outputs. Free indices are held in a circular FIFO with a speculative head, an architectural head and a tail, so a squash restores the allocation state in one cycle.

## Interface
- WIDTH, `RENAME_WIDTH: allocation lanes per cycle.
- COMMIT_WID, `COMMIT_WIDTH: dealloc lanes and commit lanes per cycle.
- NUM_PHYREGS, `IPHYREG_NUM: number of integer physical registers. Must be a power of two and at least 2*WIDTH.

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_alloc_vld  in  WIDTH  lanes requesting a new prd (has_rd && !ismv).
- o_can_alloc  out  1  free_count >= WIDTH.
- o_alloc_prd_idx  out  WIDTH x iprIdx_t  index given to each requesting lane.
- i_dealloc_vld  in  COMMIT_WID  release valid, driven by the RAT's o_dealloc_vld.
- i_dealloc_prd_idx  in  COMMIT_WID x iprIdx_t  released indices.
- i_commit_alloc_vld  in  COMMIT_WID  committed instructions that consumed a freelist entry.
- i_squash_vld  in  1  pipeline squash, same cycle as the RAT's i_squash_vld.
- o_free_count  out  clog2(NUM_PHYREGS)+1  speculative free count.
- o_dblfree_err  out  1  sticky double-free flag.

## Operation
- Storage: fifo[NUM_PHYREGS] of iprIdx_t. Pointers spec_head, arch_head and tail are clog2(NUM_PHYREGS)+1 bits wide; the extra bit is a wrap bit, and pointers wrap modulo 2*NUM_PHYREGS.
- free_count = tail - spec_head, computed modulo the pointer width.
- Reset state:
  - fifo[k] = k+1 for k in 0..NUM_PHYREGS-2. p0 is permanently mapped to x0 and every arch reg resets to p0, so p0 is never in the list.
  - spec_head = arch_head = 0; tail = NUM_PHYREGS-1.
  - o_free_count = NUM_PHYREGS-1; o_can_alloc = 1; o_dblfree_err = 0.
- Allocation fires when |i_alloc_vld && o_can_alloc && !i_squash_vld.
  - Lanes are compacted: lane i receives fifo[spec_head + popcount(i_alloc_vld[i-1:0])].
  - spec_head advances by popcount(i_alloc_vld).
  - If o_can_alloc = 0, i_alloc_vld is ignored and nothing is popped.
  - o_alloc_prd_idx is driven regardless of valid; non-requesting lanes are don't-care.
- Dealloc: valid lanes are compacted and written at tail, tail + 1, and so on; tail advances by popcount(i_dealloc_vld).
  - Dealloc is never blocked, including during a squash.
  - An index of 0 with valid set is an assertion failure and is not pushed.
- Commit: arch_head advances by popcount(i_commit_alloc_vld).
- Squash: spec_head <= arch_head + popcount(i_commit_alloc_vld), so same-cycle commits are included. The same cycle's allocation is dropped.
- Simultaneous alloc and dealloc: both apply. free_count_next = free_count - popcount(alloc) + popcount(dealloc).
- Assertions:
  - free_count never exceeds NUM_PHYREGS-1.
  - arch_head never passes spec_head.

## Timing
- Allocation is combinational: o_alloc_prd_idx and o_can_alloc come from registered state only, with no input-to-output path except the lane compaction from i_alloc_vld.
- Pushed (deallocated) indices become allocatable in the cycle after the push.
- Pointer, count and error updates take effect at the next posedge.
- Squash restore takes 1 cycle; o_can_alloc reflects the restored count in the next cycle.
- rst asserted mid-operation restores the full reset state at the next edge, discarding all in-flight state.

## Configuration
- FREELIST_DBLFREE_CHECK_EN defined:
  - Keep an NUM_PHYREGS-bit arch_free vector, reset to 1 for p1..p(N-1) and 0 for p0.
  - A bit is cleared when arch_head passes the matching entry; the index is read from fifo[arch_head+k].
  - A bit is set on push.
  - A dealloc whose bit is already set, or whose index is 0, is dropped (no push, tail does not count it) and sets o_dblfree_err (sticky until rst).
- FREELIST_DBLFREE_CHECK_EN undefined: no vector, all valid deallocs are pushed, o_dblfree_err is tied to 0.

## Test plan
Benches use WIDTH=4, COMMIT_WID=4, NUM_PHYREGS=64.
- Reset, then i_alloc_vld=4'b1111 -> lanes 0..3 get p1..p4; next cycle o_free_count=59.
- Sparse request i_alloc_vld=4'b1010 right after reset -> lane1 gets p1, lane3 gets p2; spec_head=2.
- Allocate 8 registers over 2 cycles (p1..p8), commit_alloc 2, then squash -> next 4'b1111 allocation returns p3..p6; o_free_count=61 after the squash.
- Drain until o_free_count=3 -> o_can_alloc=0 and i_alloc_vld=4'b1111 pops nothing. Dealloc p1 -> next cycle o_can_alloc=1.
- Long run (more than 64 entries through the FIFO) with a steady-state loop of alloc 4 / commit 4 / dealloc 4 -> pointers wrap, indices return in FIFO order, no assertion fires.
- With FREELIST_DBLFREE_CHECK_EN: dealloc p10 while p10 is still free -> push is dropped, o_dblfree_err=1 next cycle, o_free_count is unchanged.
